// File: rtl/frv_rng_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frv_rng_arb_pkg
// Description : Shared types, status codes and round-robin helper for the
//               two-requester RNG arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package frv_rng_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RSP   = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    // Reserved status code; kept apart from the codes the RNG itself returns.
    localparam logic [2:0] RNG_IF_TIMEOUT = 3'b111;

    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last_grant);
        logic [1:0] pick;
        if (valid == 2'b11) begin
            pick = last_grant ? 2'b01 : 2'b10;
        end else begin
            pick = valid;
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frv_rng_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : frv_rng_arb_rr
// Description : Combinational 2-way round-robin picker, one-hot grant out.
// Revision    : 1.0 - initial release
// ============================================================================
module frv_rng_arb_rr
    import frv_rng_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    assign grant_o = rr_pick(valid_i, last_grant_i);

endmodule
`default_nettype wire

// File: rtl/frv_rng_arb.sv
`default_nettype none
// ============================================================================
// Module      : frv_rng_arb
// Description : Arbitrates the CPU pipeline (r0) and crypto coprocessor (r1)
//               onto one external RNG, one transaction outstanding at a time.
//               Define FRV_RNG_ARB_TIMEOUT_EN to enable the response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module frv_rng_arb
    import frv_rng_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        r0_req_valid,
    input  logic [2:0]  r0_req_op,
    input  logic [31:0] r0_req_data,
    output logic        r0_req_ready,
    output logic        r0_rsp_valid,
    output logic [2:0]  r0_rsp_status,
    output logic [31:0] r0_rsp_data,
    input  logic        r0_rsp_ready,
    input  logic        r0_flush,
    input  logic        r1_req_valid,
    input  logic [2:0]  r1_req_op,
    input  logic [31:0] r1_req_data,
    output logic        r1_req_ready,
    output logic        r1_rsp_valid,
    output logic [2:0]  r1_rsp_status,
    output logic [31:0] r1_rsp_data,
    input  logic        r1_rsp_ready,
    output logic        rng_req_valid,
    output logic [2:0]  rng_req_op,
    output logic [31:0] rng_req_data,
    input  logic        rng_req_ready,
    input  logic        rng_rsp_valid,
    input  logic [2:0]  rng_rsp_status,
    input  logic [31:0] rng_rsp_data,
    output logic        rng_rsp_ready
);

    arb_state_e  state_q;
    logic [1:0]  grant_q;
    logic        last_q;
    logic        req_valid_q;
    logic [2:0]  req_op_q;
    logic [31:0] req_data_q;

    logic [1:0]  w_pick;
    logic        w_idle_ok;
    logic        w_flush_req;
    logic        w_flush_rsp;
    logic        w_gnt_rdy;
    logic        w_timed_out;
    logic        w_rsp_valid;
    logic [2:0]  w_rsp_status;
    logic [31:0] w_rsp_data;
    logic        w_rsp_done;

    if ((TIMEOUT < 1) || (TIMEOUT > 1023)) begin : g_timeout_chk
        $error("frv_rng_arb: TIMEOUT must be in 1..1023");
    end

    frv_rng_arb_rr u_rr (
        .valid_i      ({r1_req_valid, r0_req_valid}),
        .last_grant_i (last_q),
        .grant_o      (w_pick)
    );

    assign w_idle_ok    = (state_q == ST_IDLE) && !g_reset;
    assign r0_req_ready = w_idle_ok && w_pick[0];
    assign r1_req_ready = w_idle_ok && w_pick[1];

    assign rng_req_valid = req_valid_q;
    assign rng_req_op    = req_op_q;
    assign rng_req_data  = req_data_q;

    assign w_flush_req = (state_q == ST_REQ) && grant_q[0] && r0_flush;
    assign w_flush_rsp = (state_q == ST_RSP) && grant_q[0] && r0_flush;
    assign w_gnt_rdy   = grant_q[0] ? r0_rsp_ready : r1_rsp_ready;

`ifdef FRV_RNG_ARB_TIMEOUT_EN
    localparam logic [9:0] TO_LIMIT = 10'(TIMEOUT - 1);
    logic [9:0] to_cnt_q;

    // Counts from zero on the first RSP/DRAIN cycle, saturating at the limit.
    always_ff @(posedge g_clk) begin
        if (g_reset || (state_q == ST_IDLE) || (state_q == ST_REQ) || w_flush_rsp) begin
            to_cnt_q <= '0;
        end else if (!w_timed_out) begin
            to_cnt_q <= to_cnt_q + 10'd1;
        end
    end

    assign w_timed_out = ((state_q == ST_RSP) || (state_q == ST_DRAIN)) && (to_cnt_q == TO_LIMIT);
`else
    assign w_timed_out = 1'b0;
`endif

    // A flush in RSP still accepts the RNG response that cycle so DRAIN never waits for a second one.
    always_comb begin
        rng_rsp_ready = 1'b0;
        w_rsp_valid   = 1'b0;
        w_rsp_status  = '0;
        w_rsp_data    = '0;
        case (state_q)
            ST_RSP: begin
                if (w_flush_rsp) begin
                    rng_rsp_ready = 1'b1;
                end else if (w_timed_out) begin
                    w_rsp_valid  = 1'b1;
                    w_rsp_status = RNG_IF_TIMEOUT;
                end else begin
                    rng_rsp_ready = w_gnt_rdy;
                    w_rsp_valid   = rng_rsp_valid;
                    w_rsp_status  = rng_rsp_status;
                    w_rsp_data    = rng_rsp_data;
                end
            end
            ST_DRAIN: rng_rsp_ready = 1'b1;
            default:  rng_rsp_ready = 1'b0;
        endcase
        w_rsp_done = w_rsp_valid ? w_gnt_rdy : (rng_rsp_ready && rng_rsp_valid);
    end

    assign r0_rsp_valid  = w_rsp_valid && grant_q[0];
    assign r0_rsp_status = grant_q[0] ? w_rsp_status : '0;
    assign r0_rsp_data   = grant_q[0] ? w_rsp_data   : '0;
    assign r1_rsp_valid  = w_rsp_valid && grant_q[1];
    assign r1_rsp_status = grant_q[1] ? w_rsp_status : '0;
    assign r1_rsp_data   = grant_q[1] ? w_rsp_data   : '0;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= 1'b1;
            req_valid_q <= 1'b0;
            req_op_q    <= '0;
            req_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|w_pick) begin
                        state_q     <= ST_REQ;
                        grant_q     <= w_pick;
                        req_valid_q <= 1'b1;
                        req_op_q    <= w_pick[0] ? r0_req_op   : r1_req_op;
                        req_data_q  <= w_pick[0] ? r0_req_data : r1_req_data;
                    end
                end
                ST_REQ: begin
                    if (w_flush_req || rng_req_ready) begin
                        req_valid_q <= 1'b0;
                        req_op_q    <= '0;
                        req_data_q  <= '0;
                        if (!rng_req_ready) begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                            last_q  <= grant_q[1];
                        end else if (w_flush_req) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_RSP;
                        end
                    end
                end
                ST_RSP: begin
                    if (w_rsp_done) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        last_q  <= grant_q[1];
                    end else if (w_flush_rsp) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rng_rsp_valid || w_timed_out) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        last_q  <= grant_q[1];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frv_rng_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_frv_rng_arb
// Description : Self-checking bench for frv_rng_arb with a transaction-level
//               round-robin reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frv_rng_arb;

    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        g_reset;
    logic        r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready, r0_flush;
    logic [2:0]  r0_req_op, r0_rsp_status;
    logic [31:0] r0_req_data, r0_rsp_data;
    logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
    logic [2:0]  r1_req_op, r1_rsp_status;
    logic [31:0] r1_req_data, r1_rsp_data;
    logic        rng_req_valid, rng_req_ready, rng_rsp_valid, rng_rsp_ready;
    logic [2:0]  rng_req_op, rng_rsp_status;
    logic [31:0] rng_req_data, rng_rsp_data;

    frv_rng_arb #(.TIMEOUT(TIMEOUT)) dut (
        .g_clk(clk), .g_reset(g_reset),
        .r0_req_valid(r0_req_valid), .r0_req_op(r0_req_op), .r0_req_data(r0_req_data),
        .r0_req_ready(r0_req_ready), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_status(r0_rsp_status),
        .r0_rsp_data(r0_rsp_data), .r0_rsp_ready(r0_rsp_ready), .r0_flush(r0_flush),
        .r1_req_valid(r1_req_valid), .r1_req_op(r1_req_op), .r1_req_data(r1_req_data),
        .r1_req_ready(r1_req_ready), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_status(r1_rsp_status),
        .r1_rsp_data(r1_rsp_data), .r1_rsp_ready(r1_rsp_ready),
        .rng_req_valid(rng_req_valid), .rng_req_op(rng_req_op), .rng_req_data(rng_req_data),
        .rng_req_ready(rng_req_ready), .rng_rsp_valid(rng_rsp_valid), .rng_rsp_status(rng_rsp_status),
        .rng_rsp_data(rng_rsp_data), .rng_rsp_ready(rng_rsp_ready)
    );

    logic [110:0] all_out;
    assign all_out = {rng_req_valid, rng_req_op, rng_req_data, rng_rsp_ready,
                      r0_req_ready, r1_req_ready,
                      r0_rsp_valid, r0_rsp_status, r0_rsp_data,
                      r1_rsp_valid, r1_rsp_status, r1_rsp_data};

    int n_tests = 0;
    int n_fail  = 0;
    int m_last  = 1;   // reference model: requester granted by the last finished transaction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle_inputs();
        r0_req_valid = 0; r0_req_op = 0; r0_req_data = 0; r0_rsp_ready = 0; r0_flush = 0;
        r1_req_valid = 0; r1_req_op = 0; r1_req_data = 0; r1_rsp_ready = 0;
        rng_req_ready = 0; rng_rsp_valid = 0; rng_rsp_status = 0; rng_rsp_data = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        g_reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        g_reset = 1'b0;
        m_last  = 1;
    endtask

    // Issues an r0 request and lets the RNG accept it; returns at the negedge of the first RSP cycle.
    task automatic start_r0(input logic [2:0] op, input logic [31:0] data);
        @(negedge clk);
        r0_req_valid = 1; r0_req_op = op; r0_req_data = data;
        @(negedge clk);
        r0_req_valid = 0; rng_req_ready = 1;
        @(negedge clk);
        rng_req_ready = 0;
    endtask

    // One complete transaction from IDLE; the winner comes from the round-robin rules.
    task automatic run_txn(input bit v0, input bit v1, input int req_wait, input int rsp_lat,
                           input int bp, output int win);
        logic [2:0]  op0, op1, exp_op, st;
        logic [31:0] d0, d1, exp_data, rd;
        logic        wv, lv;
        logic [2:0]  ws;
        logic [31:0] wd;
        int          w;
        op0 = 3'($urandom); op1 = 3'($urandom); d0 = $urandom; d1 = $urandom;
        w = (v0 && v1) ? ((m_last == 0) ? 1 : 0) : (v0 ? 0 : 1);
        exp_op   = (w == 0) ? op0 : op1;
        exp_data = (w == 0) ? d0 : d1;

        @(negedge clk);
        idle_inputs();
        r0_req_valid = v0; r0_req_op = op0; r0_req_data = d0;
        r1_req_valid = v1; r1_req_op = op1; r1_req_data = d1;
        #1;
        n_tests++;
        if (r0_req_ready !== (w == 0) || r1_req_ready !== (w == 1) || rng_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL grant: r0_ready=%b r1_ready=%b rng_req_valid=%b, required winner r%0d, rng_req_valid 0",
                     r0_req_ready, r1_req_ready, rng_req_valid, w);
        end
        win = (r1_req_ready === 1'b1) ? 1 : 0;

        for (int i = 0; i <= req_wait; i++) begin
            @(negedge clk);
            r0_req_valid = 0; r1_req_valid = 0;
            rng_req_ready = (i == req_wait);
            r0_flush = (w == 1) ? 1'($urandom) : 1'b0;
            #1;
            n_tests++;
            if (rng_req_valid !== 1'b1 || rng_req_op !== exp_op || rng_req_data !== exp_data ||
                rng_rsp_ready !== 1'b0 || r0_req_ready !== 1'b0 || r1_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rng_req: valid=%b op=%0d data=%h rsp_ready=%b, required 1 %0d %h 0",
                         rng_req_valid, rng_req_op, rng_req_data, rng_rsp_ready, exp_op, exp_data);
            end
        end

        for (int i = 0; i < rsp_lat; i++) begin
            @(negedge clk);
            rng_req_ready = 0;
            r0_flush = (w == 1) ? 1'($urandom) : 1'b0;
            #1;
            n_tests++;
            if (rng_req_valid !== 1'b0 || rng_req_op !== 3'd0 || rng_req_data !== 32'd0 ||
                r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rsp_wait: rng_req_valid=%b op=%0d data=%h r0_rsp_valid=%b r1_rsp_valid=%b, required all 0",
                         rng_req_valid, rng_req_op, rng_req_data, r0_rsp_valid, r1_rsp_valid);
            end
        end

        rd = $urandom;
        st = 3'($urandom_range(0, 6));
        for (int j = 0; j <= bp; j++) begin
            @(negedge clk);
            rng_req_ready = 0;
            rng_rsp_valid = 1; rng_rsp_data = rd; rng_rsp_status = st;
            r0_rsp_ready = (w == 0) ? (j == bp) : 1'($urandom);
            r1_rsp_ready = (w == 1) ? (j == bp) : 1'($urandom);
            r0_flush = (w == 1) ? 1'($urandom) : 1'b0;
            #1;
            wv = (w == 0) ? r0_rsp_valid  : r1_rsp_valid;
            ws = (w == 0) ? r0_rsp_status : r1_rsp_status;
            wd = (w == 0) ? r0_rsp_data   : r1_rsp_data;
            lv = (w == 0) ? r1_rsp_valid  : r0_rsp_valid;
            n_tests++;
            if (wv !== 1'b1 || ws !== st || wd !== rd || lv !== 1'b0 || rng_rsp_ready !== (j == bp)) begin
                n_fail++;
                $display("FAIL rsp_route r%0d: valid=%b status=%0d data=%h other_valid=%b rng_rsp_ready=%b, required 1 %0d %h 0 %b",
                         w, wv, ws, wd, lv, rng_rsp_ready, st, rd, (j == bp));
            end
        end
        m_last = w;

        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++;
        if (rng_rsp_ready !== 1'b0 || r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0 || rng_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_txn: rng_rsp_ready=%b r0_rsp_valid=%b r1_rsp_valid=%b rng_req_valid=%b, required all 0",
                     rng_rsp_ready, r0_rsp_valid, r1_rsp_valid, rng_req_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h, required 0", all_out);
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        d = $urandom;
        @(negedge clk);
        idle_inputs();
        r0_req_valid = 1; r0_req_op = 3'b010; r0_req_data = d;
        #1;
        n_tests++;
        if (r0_req_ready !== 1'b1 || rng_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: r0_req_ready=%b rng_req_valid=%b, required 1 0", r0_req_ready, rng_req_valid);
        end
        @(negedge clk);
        r0_req_valid = 0; rng_req_ready = 1;
        #1;
        n_tests++;
        if (rng_req_valid !== 1'b1 || rng_req_op !== 3'b010 || rng_req_data !== d) begin
            n_fail++;
            $display("FAIL single_latency: rng_req_valid=%b op=%0d data=%h, required 1 2 %h", rng_req_valid, rng_req_op, rng_req_data, d);
        end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            rng_req_ready = 0; r0_rsp_ready = 1;
            rng_rsp_valid = (c == 2); rng_rsp_data = 32'hDEADBEEF; rng_rsp_status = 3'd0;
            #1;
            n_tests++;
            if (r0_rsp_valid !== (c == 2) || (c == 2 && r0_rsp_data !== 32'hDEADBEEF) ||
                r1_rsp_valid !== 1'b0 || r1_rsp_data !== 32'd0 || r1_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL single_rsp c%0d: r0_valid=%b r0_data=%h r1_valid=%b r1_data=%h, required %b deadbeef 0 0",
                         c, r0_rsp_valid, r0_rsp_data, r1_rsp_valid, r1_rsp_data, (c == 2));
            end
        end
        @(negedge clk);
        idle_inputs();
        m_last = 0;
    endtask

    task automatic test_round_robin();
        int win;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_txn(1'b1, 1'b1, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), win);
            n_tests++;
            if (win != (k % 2)) begin
                n_fail++;
                $display("FAIL rr_tie %0d: granted r%0d, required r%0d", k, win, k % 2);
            end
        end
    endtask

    task automatic test_flush();
        int win;
        // Flush while the RNG has not yet accepted: request is dropped.
        @(negedge clk);
        idle_inputs();
        r0_req_valid = 1; r0_req_op = 3'd1; r0_req_data = $urandom;
        @(negedge clk);
        r0_req_valid = 0; r0_flush = 1;
        #1;
        n_tests++;
        if (rng_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_req_pre: rng_req_valid=%b, required 1", rng_req_valid);
        end
        @(negedge clk);
        r0_flush = 0;
        #1;
        n_tests++;
        if (rng_req_valid !== 1'b0 || rng_rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_req_drop: rng_req_valid=%b rng_rsp_ready=%b, required 0 0", rng_req_valid, rng_rsp_ready);
        end
        run_txn(1'b0, 1'b1, 0, 1, 0, win);

        // Flush during RSP: the late RNG response is drained.
        start_r0(3'd3, $urandom);
        r0_flush = 1; r0_rsp_ready = 1;
        #1;
        n_tests++;
        if (r0_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_rsp: r0_rsp_valid=%b, required 0", r0_rsp_valid);
        end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            r0_flush = 0;
            rng_rsp_valid = (c == 5); rng_rsp_data = $urandom;
            #1;
            n_tests++;
            if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0 || rng_rsp_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL drain c%0d: r0_rsp_valid=%b r1_rsp_valid=%b rng_rsp_ready=%b, required 0 0 1",
                         c, r0_rsp_valid, r1_rsp_valid, rng_rsp_ready);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++;
        if (rng_rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_exit: rng_rsp_ready=%b, required 0", rng_rsp_ready);
        end
        run_txn(1'b0, 1'b1, 1, 2, 1, win);
    endtask

    task automatic test_timeout();
        int win;
        start_r0(3'd5, $urandom);
`ifdef FRV_RNG_ARB_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            r0_rsp_ready = (c == 8);
            #1;
            n_tests++;
            if (c < 8 && r0_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early c%0d: r0_rsp_valid=%b, required 0", c, r0_rsp_valid);
            end else if (c == 8 && (r0_rsp_valid !== 1'b1 || r0_rsp_status !== 3'b111 ||
                                    r0_rsp_data !== 32'd0 || r1_rsp_valid !== 1'b0)) begin
                n_fail++;
                $display("FAIL timeout_rsp: valid=%b status=%0d data=%h r1_valid=%b, required 1 7 0 0",
                         r0_rsp_valid, r0_rsp_status, r0_rsp_data, r1_rsp_valid);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++;
        if (r0_rsp_valid !== 1'b0 || rng_rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_exit: r0_rsp_valid=%b rng_rsp_ready=%b, required 0 0", r0_rsp_valid, rng_rsp_ready);
        end
`else
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            n_tests++;
            if (r0_rsp_valid !== 1'b0 || rng_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL no_timeout c%0d: r0_rsp_valid=%b rng_req_valid=%b, required 0 0", c, r0_rsp_valid, rng_req_valid);
            end
        end
        @(negedge clk);
        rng_rsp_valid = 1; rng_rsp_data = 32'h0BADF00D; rng_rsp_status = 3'd1; r0_rsp_ready = 1;
        #1;
        n_tests++;
        if (r0_rsp_valid !== 1'b1 || r0_rsp_data !== 32'h0BADF00D || r0_rsp_status !== 3'd1 || rng_rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL still_rsp: valid=%b data=%h status=%0d rng_rsp_ready=%b, required 1 0badf00d 1 1",
                     r0_rsp_valid, r0_rsp_data, r0_rsp_status, rng_rsp_ready);
        end
        @(negedge clk);
        idle_inputs();
`endif
        run_txn(1'b0, 1'b1, 0, 0, 0, win);
    endtask

    task automatic test_reset_in_req();
        int win;
        @(negedge clk);
        idle_inputs();
        r0_req_valid = 1; r0_req_op = 3'd6; r0_req_data = $urandom;
        @(negedge clk);
        r0_req_valid = 0; rng_req_ready = 0; g_reset = 1;
        #1;
        n_tests++;
        if (rng_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_req_pre: rng_req_valid=%b, required 1", rng_req_valid);
        end
        @(negedge clk);
        g_reset = 0;
        rng_rsp_valid = 1; rng_rsp_data = $urandom;
        #1;
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_in_req: outputs %h, required 0", all_out);
        end
        m_last = 1;
        run_txn(1'b0, 1'b1, 0, 1, 0, win);
    endtask

    task automatic test_random();
        int          win;
        logic [1:0]  v;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            v = 2'($urandom_range(1, 3));
            run_txn(v[0], v[1], $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), win);
        end
    endtask

    initial begin
        g_reset = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_flush();
        test_timeout();
        test_reset_in_req();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
